// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP framing constants for the packetizer and depacketizer.
// Header word indices assume a 32-bit MAC stream with a 16-bit pad ahead of the destination MAC.
// Also holds the depacketizer state encoding.
package eth_pkg;

  // Header word indices within the 32-bit stream
  localparam logic [3:0] HDR_IDX_DMAC_HI  = 4'd0;   // {pad16, dmac[47:32]}
  localparam logic [3:0] HDR_IDX_DMAC_LO  = 4'd1;   // dmac[31:0]
  localparam logic [3:0] HDR_IDX_SMAC_HI  = 4'd2;   // smac[47:16]
  localparam logic [3:0] HDR_IDX_ETYPE    = 4'd3;   // {smac[15:0], ethertype}
  localparam logic [3:0] HDR_IDX_IP_VER   = 4'd4;   // {ver/ihl, tos, totlen}
  localparam logic [3:0] HDR_IDX_IP_FRAG  = 4'd5;   // {id, flags/frag}
  localparam logic [3:0] HDR_IDX_IP_PROTO = 4'd6;   // {ttl, proto, csum}
  localparam logic [3:0] HDR_IDX_IP_SRC   = 4'd7;   // sip
  localparam logic [3:0] HDR_IDX_IP_DST   = 4'd8;   // dip
  localparam logic [3:0] HDR_IDX_UDP_PORT = 4'd9;   // {sport, dport}
  localparam logic [3:0] HDR_IDX_UDP_LEN  = 4'd10;  // {udplen, ucsum}
  localparam logic [3:0] HDR_IDX_LAST     = HDR_IDX_UDP_LEN;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [15:0] UDP_HDR_BYTES  = 16'd8;

  // Depacketizer FSM encoding
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_PAD     = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;

endpackage

// File: rtl/depkt_hdr_check.sv
// Per-word header match: compares one header word, selected by idx, against the local identity.
// Latency: combinational. Backpressure: none (pure function of the current word).
// Ports: idx (header word index), data (stream word), match (word acceptable), udplen (data[31:16]).
module depkt_hdr_check
  import eth_pkg::*;
#(
  parameter logic [47:0] source_mac        = 48'h021234566790,
  parameter logic [31:0] source_ip         = {8'd192, 8'd168, 8'd50, 8'd50},
  parameter logic [15:0] source_port       = 16'd32179,
  parameter int          MAX_PAYLOAD_WORDS = 368
) (
  input  logic [3:0]  idx,
  input  logic [31:0] data,
  output logic        match,
  output logic [15:0] udplen
);

  // (udplen-8)/4 <= MAX with udplen word-aligned is the same as udplen <= 8 + 4*MAX
  localparam logic [15:0] MAX_UDPLEN = 16'(UDP_HDR_BYTES + 16'(4 * MAX_PAYLOAD_WORDS));

  assign udplen = data[31:16];

  always_comb begin
    match = 1'b0;
    case (idx)
      HDR_IDX_DMAC_HI:  match = (data[15:0] == source_mac[47:32]);
      HDR_IDX_DMAC_LO:  match = (data == source_mac[31:0]);
      HDR_IDX_SMAC_HI:  match = 1'b1;
      HDR_IDX_ETYPE:    match = (data[15:0] == ETHERTYPE_IPV4);
      HDR_IDX_IP_VER:   match = (data[31:24] == IP_VER_IHL);
      // MF is bit 13; fragment offset is [12:0]; DF is don't-care
      HDR_IDX_IP_FRAG:  match = (data[13:0] == 14'd0);
      HDR_IDX_IP_PROTO: match = (data[23:16] == IP_PROTO_UDP);
      HDR_IDX_IP_SRC:   match = 1'b1;
      HDR_IDX_IP_DST:   match = (data == source_ip);
      HDR_IDX_UDP_PORT: match = (data[15:0] == source_port);
      HDR_IDX_UDP_LEN:  match = (udplen >= 16'd12) && (udplen[1:0] == 2'b00) &&
                                (udplen <= MAX_UDPLEN);
      default:          match = 1'b0;
    endcase
  end

endmodule

// File: rtl/depacketizer.sv
// Receive UDP depacketizer: parses Eth/IPv4/UDP from the MAC rx stream, filters on local
// MAC/IP/port and writes payload words downstream; bad frames are dropped whole.
// Latency: rx word -> wr_en 1 cycle; eop -> pkt_ok/pkt_drop 1 cycle.
// Backpressure: ff_rx_rdy = registered ~wr_afull; every valid word is accepted regardless.
// Ports: clk, reset_n (sync, active-low); ff_rx_* MAC stream in, ff_rx_rdy out; rx_err on eop;
//        wr_afull in, wr_en/wr_data/wr_sop/wr_eop out; pkt_ok/pkt_drop pulses; good_cnt/drop_cnt.
module depacketizer
  import eth_pkg::*;
#(
  parameter logic [47:0] source_mac        = 48'h021234566790,
  parameter logic [31:0] source_ip         = {8'd192, 8'd168, 8'd50, 8'd50},
  parameter logic [15:0] source_port       = 16'd32179,
  parameter int          MAX_PAYLOAD_WORDS = 368
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ff_rx_data,
  input  logic        ff_rx_sop,
  input  logic        ff_rx_eop,
  input  logic [1:0]  ff_rx_mod,
  input  logic        ff_rx_dval,
  input  logic [5:0]  rx_err,
  output logic        ff_rx_rdy,
  input  logic        wr_afull,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic        wr_sop,
  output logic        wr_eop,
  output logic        pkt_ok,
  output logic        pkt_drop,
  output logic [15:0] good_cnt,
  output logic [15:0] drop_cnt
);

  localparam int REM_W = $clog2(MAX_PAYLOAD_WORDS + 1);

  logic [2:0]       state, state_nx;
  logic [3:0]       idx, idx_nx;
  logic             match_q, match_nx;
  logic [REM_W-1:0] remaining, remaining_nx;
  logic             pl_first, pl_first_nx;

  logic             wr_en_nx, wr_sop_nx, wr_eop_nx, ok_nx, drop_nx;
  logic [31:0]      wr_data_nx;

  logic [3:0]       chk_idx;
  logic             word_match;
  logic [15:0]      udplen;
  logic [15:0]      pl_bytes;
  logic             unused_bits;

  // A sop word is always header word 0, whatever state the FSM is in
  assign chk_idx  = ff_rx_sop ? HDR_IDX_DMAC_HI : idx;
  assign pl_bytes = udplen - UDP_HDR_BYTES;
  // Payload is word-exact, so byte-empty count and the sub-word length bits carry no information
  assign unused_bits = ^{ff_rx_mod, pl_bytes[15:REM_W+2], pl_bytes[1:0]};

  depkt_hdr_check #(
    .source_mac        (source_mac),
    .source_ip         (source_ip),
    .source_port       (source_port),
    .MAX_PAYLOAD_WORDS (MAX_PAYLOAD_WORDS)
  ) u_hdr_check (
    .idx    (chk_idx),
    .data   (ff_rx_data),
    .match  (word_match),
    .udplen (udplen)
  );

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    match_nx     = match_q;
    remaining_nx = remaining;
    pl_first_nx  = pl_first;
    wr_en_nx     = 1'b0;
    wr_data_nx   = ff_rx_data;
    wr_sop_nx    = 1'b0;
    wr_eop_nx    = 1'b0;
    ok_nx        = 1'b0;
    drop_nx      = 1'b0;

    if (ff_rx_dval) begin
      if (ff_rx_sop) begin
        // Abort whatever was in flight; close an open payload with an empty eop word
        if (state != S_IDLE) drop_nx = 1'b1;
        if (state == S_PAYLOAD && !pl_first) begin
          wr_en_nx   = 1'b1;
          wr_eop_nx  = 1'b1;
          wr_data_nx = 32'd0;
        end
        if (ff_rx_eop) begin
          drop_nx  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_HDR;
          idx_nx   = HDR_IDX_DMAC_HI + 4'd1;
          match_nx = word_match;
        end
      end else begin
        case (state)
          S_HDR: begin
            if (ff_rx_eop) begin
              drop_nx  = 1'b1;
              state_nx = S_IDLE;
            end else if (idx == HDR_IDX_LAST) begin
              if (match_q && word_match) begin
                state_nx     = S_PAYLOAD;
                remaining_nx = pl_bytes[REM_W+1:2];
                pl_first_nx  = 1'b1;
              end else begin
                state_nx = S_DISCARD;
              end
            end else begin
              idx_nx   = idx + 4'd1;
              match_nx = match_q & word_match;
            end
          end
          S_PAYLOAD: begin
            wr_en_nx     = 1'b1;
            wr_sop_nx    = pl_first;
            pl_first_nx  = 1'b0;
            remaining_nx = remaining - REM_W'(1);
            wr_eop_nx    = ff_rx_eop || (remaining == REM_W'(1));
            if (ff_rx_eop) begin
              // Early eop means truncated datagram
              if (remaining == REM_W'(1) && rx_err == 6'd0) ok_nx = 1'b1;
              else drop_nx = 1'b1;
              state_nx = S_IDLE;
            end else if (remaining == REM_W'(1)) begin
              state_nx = S_PAD;
            end
          end
          S_PAD: begin
            if (ff_rx_eop) begin
              if (rx_err == 6'd0) ok_nx = 1'b1;
              else drop_nx = 1'b1;
              state_nx = S_IDLE;
            end
          end
          S_DISCARD: begin
            if (ff_rx_eop) begin
              drop_nx  = 1'b1;
              state_nx = S_IDLE;
            end
          end
          default: ;  // IDLE: words outside a frame are ignored
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      match_q   <= 1'b0;
      remaining <= '0;
      pl_first  <= 1'b0;
      ff_rx_rdy <= 1'b0;
      wr_en     <= 1'b0;
      wr_data   <= 32'd0;
      wr_sop    <= 1'b0;
      wr_eop    <= 1'b0;
      pkt_ok    <= 1'b0;
      pkt_drop  <= 1'b0;
      good_cnt  <= 16'd0;
      drop_cnt  <= 16'd0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      match_q   <= match_nx;
      remaining <= remaining_nx;
      pl_first  <= pl_first_nx;
      ff_rx_rdy <= ~wr_afull;
      wr_en     <= wr_en_nx;
      wr_data   <= wr_data_nx;
      wr_sop    <= wr_sop_nx;
      wr_eop    <= wr_eop_nx;
      pkt_ok    <= ok_nx;
      pkt_drop  <= drop_nx;
      if (ok_nx)   good_cnt <= good_cnt + 16'd1;
      if (drop_nx) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule
